// File: rtl/raster_pkg.sv
// Types and defaults shared by the raster pipeline stages.
// The saturating increment is the common event-counter helper.
package raster_pkg;

    localparam int FRAC_BITS = 8;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int Z_W_DEF   = 16;

    typedef int fixed_t;
    typedef byte unsigned rgb_t [3];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/zbuf_ram.sv
// Single-port depth buffer with synchronous write and a one-cycle registered read.
// Written so that synthesis maps it onto block RAM.
module zbuf_ram #(
    parameter int DEPTH = 307200,
    parameter int AW    = 19,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/depth_test_writer.sv
// Fragment back end: screen clip, strict less-than Z test, Z-buffer update and framebuffer write.
// Lane 0 of pix_xyz / pix_rgb sits in the low bits (x in [31:0], r in [7:0]).
module depth_test_writer #(
    parameter int H_RES     = raster_pkg::H_RES_DEF,
    parameter int V_RES     = raster_pkg::V_RES_DEF,
    parameter int FRAC_BITS = raster_pkg::FRAC_BITS,
    parameter int Z_W       = raster_pkg::Z_W_DEF,
    localparam int ADDR_W   = $clog2(H_RES * V_RES)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [95:0]       pix_xyz,
    input  logic [23:0]       pix_rgb,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_wdata,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [31:0]       drawn_cnt,
    output logic [31:0]       reject_cnt
);

    import raster_pkg::*;

    localparam int NPIX = H_RES * V_RES;
    localparam logic [Z_W-1:0] Z_MAX = '1;
    localparam fixed_t Z_MAX_I = (1 << Z_W) - 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_COMPARE,
        S_FB_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clear_pend_q, clear_pend_d;
    logic              pix_ready_q, pix_ready_d;
    logic              busy_q, busy_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [23:0]       fb_wdata_q, fb_wdata_d;
    logic [Z_W-1:0]    z_q, z_d;
    logic [31:0]       drawn_cnt_q, drawn_cnt_d;
    logic [31:0]       reject_cnt_q, reject_cnt_d;

    fixed_t            xi, yi, zs;
    logic              clipped, accept, z_pass;
    logic [Z_W-1:0]    zq;
    logic [ADDR_W-1:0] frag_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [Z_W-1:0]    ram_wdata, ram_rdata;

    always_comb begin
        xi = fixed_t'(pix_xyz[31:0]) >>> FRAC_BITS;
        yi = fixed_t'(pix_xyz[63:32]) >>> FRAC_BITS;
        zs = fixed_t'(pix_xyz[95:64]) >>> FRAC_BITS;
        clipped = (xi < 0) || (xi >= H_RES) || (yi < 0) || (yi >= V_RES);
        if (zs < 0) begin
            zq = '0;
        end else if (zs > Z_MAX_I) begin
            zq = Z_MAX;
        end else begin
            zq = Z_W'(zs);
        end
        frag_addr = ADDR_W'(yi * H_RES + xi);
    end

    assign accept    = pix_valid && pix_ready_q;
    assign z_pass    = z_q < ram_rdata;
    assign ram_addr  = (state_q == S_CLEAR) ? clr_addr_q : fb_addr_q;
    assign ram_we    = (state_q == S_CLEAR) || ((state_q == S_COMPARE) && z_pass);
    assign ram_wdata = (state_q == S_CLEAR) ? Z_MAX : z_q;

    zbuf_ram #(
        .DEPTH(NPIX),
        .AW   (ADDR_W),
        .DW   (Z_W)
    ) u_zbuf (
        .CLK  (CLK),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clear_pend_d = clear_pend_q;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        z_d          = z_q;
        drawn_cnt_d  = drawn_cnt_q;
        reject_cnt_d = reject_cnt_q;

        case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q - ADDR_W'(1);
                if (clr_addr_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // A clear deferred behind an accepted fragment takes this IDLE cycle.
                if (clear_pend_q) begin
                    state_d      = S_CLEAR;
                    clear_pend_d = 1'b0;
                end else if (accept) begin
                    clear_pend_d = clear;
                    if (clipped) begin
                        reject_cnt_d = sat_inc(reject_cnt_q);
                    end else begin
                        state_d    = S_READ;
                        fb_addr_d  = frag_addr;
                        fb_wdata_d = {pix_rgb[7:0], pix_rgb[15:8], pix_rgb[23:16]};
                        z_d        = zq;
                    end
                end else if (clear) begin
                    state_d = S_CLEAR;
                end
            end
            S_READ: begin
                state_d      = S_COMPARE;
                clear_pend_d = clear_pend_q || clear;
            end
            S_COMPARE: begin
                clear_pend_d = clear_pend_q || clear;
                if (z_pass) begin
                    state_d     = S_FB_WRITE;
                    drawn_cnt_d = sat_inc(drawn_cnt_q);
                end else begin
                    state_d      = S_IDLE;
                    reject_cnt_d = sat_inc(reject_cnt_q);
                end
            end
            S_FB_WRITE: begin
                clear_pend_d = clear_pend_q || clear;
                if (fb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        if ((state_d == S_CLEAR) && (state_q != S_CLEAR)) begin
            clr_addr_d   = ADDR_W'(NPIX - 1);
            drawn_cnt_d  = '0;
            reject_cnt_d = '0;
        end

        pix_ready_d = (state_d == S_IDLE) && !clear_pend_d;
        busy_d      = (state_d != S_IDLE) || clear_pend_d;
        fb_we_d     = (state_d == S_FB_WRITE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= ADDR_W'(NPIX - 1);
            clear_pend_q <= 1'b0;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            z_q          <= '0;
            drawn_cnt_q  <= '0;
            reject_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clear_pend_q <= clear_pend_d;
            pix_ready_q  <= pix_ready_d;
            busy_q       <= busy_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            z_q          <= z_d;
            drawn_cnt_q  <= drawn_cnt_d;
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign busy       = busy_q;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign drawn_cnt  = drawn_cnt_q;
    assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_depth_test_writer.sv
// Directed bench for depth_test_writer on a reduced 64x48 screen to keep clears short.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_depth_test_writer;

    localparam int H    = 64;
    localparam int V    = 48;
    localparam int NPIX = H * V;
    localparam int AW   = $clog2(NPIX);

    logic          CLK = 1'b0;
    logic          RESET;
    logic          pix_valid;
    logic          pix_ready;
    logic [95:0]   pix_xyz;
    logic [23:0]   pix_rgb;
    logic          clear;
    logic          busy;
    logic [AW-1:0] fb_addr;
    logic [23:0]   fb_wdata;
    logic          fb_we;
    logic          fb_ready;
    logic [31:0]   drawn_cnt;
    logic [31:0]   reject_cnt;

    int checks = 0;
    int failures = 0;
    int fb_writes = 0;

    depth_test_writer #(.H_RES(H), .V_RES(V)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_xyz   (pix_xyz),
        .pix_rgb   (pix_rgb),
        .clear     (clear),
        .busy      (busy),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready),
        .drawn_cnt (drawn_cnt),
        .reject_cnt(reject_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (fb_we && fb_ready) fb_writes <= fb_writes + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one fragment for a single accepting cycle; caller is at a negedge with pix_ready high.
    task automatic send(input int x, input int y, input int z,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic clr);
        pix_xyz   = {z, y, x};
        pix_rgb   = {b, g, r};
        pix_valid = 1'b1;
        clear     = clr;
        @(negedge CLK);
        pix_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!pix_ready && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready: pix_ready=%b after %0d cycles, required 1", pix_ready, n);
        end
    endtask

    // Drops RESET at a negedge and counts cycles until pix_ready rises.
    task automatic release_and_count(output int n);
        RESET = 1'b0;
        n = 0;
        while (!pix_ready && n < NPIX + 20) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        int n;
        RESET = 1'b1; pix_valid = 1'b0; clear = 1'b0; fb_ready = 1'b1;
        pix_xyz = '0; pix_rgb = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({pix_ready, fb_we, busy} !== 3'b001 || fb_addr !== '0 || fb_wdata !== 24'h0
            || drawn_cnt !== 32'd0 || reject_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_values: ready=%b we=%b busy=%b addr=%0d wdata=%h drawn=%0d rej=%0d, required 0 0 1 0 0 0 0",
                     pix_ready, fb_we, busy, fb_addr, fb_wdata, drawn_cnt, reject_cnt);
        end
        release_and_count(n);
        checks++;
        if (n !== NPIX || pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_length: ready low for %0d cycles, required %0d", n, NPIX);
        end
        checks++;
        if (dut.u_zbuf.mem[0] !== 16'hFFFF || dut.u_zbuf.mem[NPIX-1] !== 16'hFFFF) begin
            failures++;
            $display("FAIL clear_contents: mem[0]=%h mem[last]=%h, required ffff",
                     dut.u_zbuf.mem[0], dut.u_zbuf.mem[NPIX-1]);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_draw;
        send(10 << 8, 20 << 8, 100 << 8, 8'd1, 8'd2, 8'd3, 1'b0);
        checks++;
        if (pix_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL draw_t1: ready=%b busy=%b, required 0 1", pix_ready, busy);
        end
        @(negedge CLK);
        checks++;
        if (fb_we !== 1'b0) begin
            failures++;
            $display("FAIL draw_t2: fb_we=%b, required 0", fb_we);
        end
        @(negedge CLK);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== AW'(1290) || fb_wdata !== 24'h010203 || drawn_cnt !== 32'd1) begin
            failures++;
            $display("FAIL draw_t3: we=%b addr=%0d wdata=%h drawn=%0d, required 1 1290 010203 1",
                     fb_we, fb_addr, fb_wdata, drawn_cnt);
        end
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b1 || fb_we !== 1'b0 || fb_writes !== 1) begin
            failures++;
            $display("FAIL draw_t4: ready=%b we=%b writes=%0d, required 1 0 1", pix_ready, fb_we, fb_writes);
        end
    endtask

    task automatic test_depth;
        int w0 = fb_writes;
        send(10 << 8, 20 << 8, 200 << 8, 8'd4, 8'd5, 8'd6, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL depth_fail_timing: ready at T+3=%b, required 1", pix_ready);
        end
        send(10 << 8, 20 << 8, 100 << 8, 8'd7, 8'd8, 8'd9, 1'b0);
        wait_ready(10);
        send(10 << 8, 20 << 8, 50 << 8, 8'hAA, 8'hBB, 8'hCC, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (fb_we !== 1'b1 || fb_wdata !== 24'hAABBCC) begin
            failures++;
            $display("FAIL depth_pass_write: we=%b wdata=%h, required 1 aabbcc", fb_we, fb_wdata);
        end
        wait_ready(10);
        checks++;
        if (reject_cnt !== 32'd2 || drawn_cnt !== 32'd2 || fb_writes - w0 !== 1
            || dut.u_zbuf.mem[1290] !== 16'd50) begin
            failures++;
            $display("FAIL depth_counts: rej=%0d drawn=%0d writes=%0d z=%0d, required 2 2 1 50",
                     reject_cnt, drawn_cnt, fb_writes - w0, dut.u_zbuf.mem[1290]);
        end
        // Negative z saturates to 0 and beats the cleared 0xFFFF.
        send(0, 0, -(5 << 8), 8'd1, 8'd1, 8'd1, 1'b0);
        wait_ready(10);
        // Huge z saturates to 0xFFFF, equal to the cleared value, so it fails.
        send(1 << 8, 0, 32'h7FFF_FF00, 8'd1, 8'd1, 8'd1, 1'b0);
        wait_ready(10);
        send((63 << 8) | 8'h80, 47 << 8, (16'h1234 << 8) | 8'hFF, 8'd9, 8'd9, 8'd9, 1'b0);
        wait_ready(10);
        checks++;
        if (drawn_cnt !== 32'd4 || reject_cnt !== 32'd3 || dut.u_zbuf.mem[0] !== 16'd0
            || dut.u_zbuf.mem[1] !== 16'hFFFF || dut.u_zbuf.mem[NPIX-1] !== 16'h1234) begin
            failures++;
            $display("FAIL z_saturation: drawn=%0d rej=%0d z0=%h z1=%h zlast=%h, required 4 3 0000 ffff 1234",
                     drawn_cnt, reject_cnt, dut.u_zbuf.mem[0], dut.u_zbuf.mem[1], dut.u_zbuf.mem[NPIX-1]);
        end
    endtask

    task automatic test_clip;
        int w0 = fb_writes;
        int xs [3] = '{-(1 << 8), H << 8, 3 << 8};
        int ys [3] = '{4 << 8, 4 << 8, V << 8};
        for (int i = 0; i < 3; i++) begin
            send(xs[i], ys[i], 1 << 8, 8'd1, 8'd2, 8'd3, 1'b0);
            checks++;
            if (pix_ready !== 1'b1 || fb_we !== 1'b0) begin
                failures++;
                $display("FAIL clip_%0d: ready=%b we=%b at T+1, required 1 0", i, pix_ready, fb_we);
            end
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (reject_cnt !== 32'd6 || fb_writes !== w0) begin
            failures++;
            $display("FAIL clip_counts: rej=%0d writes=%0d, required 6 %0d", reject_cnt, fb_writes, w0);
        end
    endtask

    task automatic test_stall;
        fb_ready = 1'b0;
        send(5 << 8, 5 << 8, 10 << 8, 8'h11, 8'h22, 8'h33, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (fb_we !== 1'b1 || fb_addr !== AW'(325) || fb_wdata !== 24'h112233
                || pix_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_%0d: we=%b addr=%0d wdata=%h ready=%b busy=%b, required 1 325 112233 0 1",
                         i, fb_we, fb_addr, fb_wdata, pix_ready, busy);
            end
            if (i < 9) @(negedge CLK);
        end
        fb_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b1 || fb_we !== 1'b0 || drawn_cnt !== 32'd5) begin
            failures++;
            $display("FAIL stall_release: ready=%b we=%b drawn=%0d, required 1 0 5", pix_ready, fb_we, drawn_cnt);
        end
    endtask

    task automatic test_clear_pending;
        send(7 << 8, 3 << 8, 10 << 8, 8'h44, 8'h55, 8'h66, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== AW'(199)) begin
            failures++;
            $display("FAIL pend_frag_wins: we=%b addr=%0d, required 1 199", fb_we, fb_addr);
        end
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pend_hold: ready=%b busy=%b, required 0 1", pix_ready, busy);
        end
        @(negedge CLK);
        checks++;
        if (drawn_cnt !== 32'd0 || reject_cnt !== 32'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pend_clear_entry: drawn=%0d rej=%0d busy=%b, required 0 0 1", drawn_cnt, reject_cnt, busy);
        end
        wait_ready(NPIX + 20);
        checks++;
        if (dut.u_zbuf.mem[199] !== 16'hFFFF || dut.u_zbuf.mem[1290] !== 16'hFFFF) begin
            failures++;
            $display("FAIL pend_cleared: z199=%h z1290=%h, required ffff", dut.u_zbuf.mem[199], dut.u_zbuf.mem[1290]);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int w0 = fb_writes;
        fb_ready = 1'b0;
        send(9 << 8, 9 << 8, 10 << 8, 8'h77, 8'h88, 8'h99, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (fb_we !== 1'b1 || drawn_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rst_mid_setup: we=%b drawn=%0d, required 1 1", fb_we, drawn_cnt);
        end
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (fb_we !== 1'b0 || drawn_cnt !== 32'd0 || reject_cnt !== 32'd0 || pix_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_abort: we=%b drawn=%0d rej=%0d ready=%b busy=%b, required 0 0 0 0 1",
                     fb_we, drawn_cnt, reject_cnt, pix_ready, busy);
        end
        fb_ready = 1'b1;
        release_and_count(n);
        checks++;
        if (n !== NPIX || fb_writes !== w0 || dut.u_zbuf.mem[585] !== 16'hFFFF) begin
            failures++;
            $display("FAIL rst_mid_clear: ready after %0d writes=%0d z585=%h, required %0d %0d ffff",
                     n, fb_writes, dut.u_zbuf.mem[585], NPIX, w0);
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_draw();
        test_depth();
        test_clip();
        test_stall();
        test_clear_pending();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
